// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: decoded element, queue entry, FU indices.
package issue_scheduler_pkg;

    localparam int IQ_MAX_FU = 3;

    localparam int FU_ALU = 0;
    localparam int FU_MEM = 1;
    localparam int FU_BR  = 2;

    typedef struct packed {
        logic [5:0]           opcode;
        logic [4:0]           dest_addr;
        logic [IQ_MAX_FU-1:0] accept_mask;
        logic                 num1_need;
        logic [4:0]           num1_addr;
        logic [31:0]          num1;
        logic                 num2_need;
        logic [4:0]           num2_addr;
        logic [31:0]          num2;
    } ISSUE_QUEUE_ELEMENT;

    typedef struct packed {
        logic               valid;
        logic               src1_rdy;
        logic               src2_rdy;
        ISSUE_QUEUE_ELEMENT elem;
    } IQ_ENTRY;

endpackage

// File: rtl/issue_scheduler_if.sv
// Decoder enqueue, writeback snoop and FU issue signals of the issue scheduler.
interface issue_scheduler_if
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int NUM_FU   = 3,
    parameter int WB_PORTS = 2
);
    logic                               flush;
    logic                               enq_valid;
    logic                               enq_ready;
    ISSUE_QUEUE_ELEMENT                 enq_elem;
    logic                               enq_src1_rdy;
    logic [31:0]                        enq_src1_data;
    logic                               enq_src2_rdy;
    logic [31:0]                        enq_src2_data;
    logic [WB_PORTS-1:0]                wb_valid;
    logic [WB_PORTS-1:0][4:0]           wb_addr;
    logic [WB_PORTS-1:0][31:0]          wb_data;
    logic [NUM_FU-1:0]                  iss_valid;
    logic [NUM_FU-1:0]                  iss_ready;
    ISSUE_QUEUE_ELEMENT [NUM_FU-1:0]    iss_elem;
    logic [$clog2(DEPTH):0]             count;

    modport master (
        output flush, enq_valid, enq_elem, enq_src1_rdy, enq_src1_data,
               enq_src2_rdy, enq_src2_data, wb_valid, wb_addr, wb_data, iss_ready,
        input  enq_ready, iss_valid, iss_elem, count
    );

    modport slave (
        input  flush, enq_valid, enq_elem, enq_src1_rdy, enq_src1_data,
               enq_src2_rdy, enq_src2_data, wb_valid, wb_addr, wb_data, iss_ready,
        output enq_ready, iss_valid, iss_elem, count
    );
endinterface

// File: rtl/issue_scheduler_picker.sv
// Oldest-first picker: grants the lowest-index request not masked by excl.
module iq_oldest_picker #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         req,
    input  logic [DEPTH-1:0]         excl,
    output logic [DEPTH-1:0]         grant,
    output logic                     valid,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int IW = $clog2(DEPTH);

    // Priority encode from index 0 (oldest) upward.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (req[i] && !excl[i] && !valid) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
                idx      = IW'(i);
            end
        end
    end
endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: compacting age-ordered storage, wakeup from
// writeback broadcasts, and oldest-ready selection per FU port.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int NUM_FU   = 3,
    parameter int WB_PORTS = 2
) (
    input logic               clk,
    input logic               rst_n,
    issue_scheduler_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    IQ_ENTRY           q      [DEPTH];
    IQ_ENTRY           q_next [DEPTH];
    IQ_ENTRY           woken  [DEPTH];
    IQ_ENTRY           enq_entry;
    logic [32:0]       wake1  [DEPTH];
    logic [32:0]       wake2  [DEPTH];
    logic [32:0]       enq_hit1, enq_hit2;
    logic [CW-1:0]     count_q, count_next, ptr;
    logic              enq_fire;
    logic [DEPTH-1:0]  req    [NUM_FU];
    logic [DEPTH-1:0]  excl   [NUM_FU];
    logic [DEPTH-1:0]  grant  [NUM_FU];
    logic [IW-1:0]     pick_idx [NUM_FU];
    logic [NUM_FU-1:0] pick_v;
    logic [DEPTH-1:0]  remove;

    // {hit, data} for a register address on the writeback bus; highest port wins, r0 never matches.
    function automatic logic [32:0] wb_snoop(
        input logic [4:0]                 addr,
        input logic [WB_PORTS-1:0]        v,
        input logic [WB_PORTS-1:0][4:0]   a,
        input logic [WB_PORTS-1:0][31:0]  d
    );
        logic [32:0] r;
        r = '0;
        for (int unsigned w = 0; w < WB_PORTS; w++) begin
            if (v[w] && a[w] == addr && addr != '0) r = {1'b1, d[w]};
        end
        return r;
    endfunction

    assign bus.enq_ready = (count_q < CW'(DEPTH));
    assign bus.count     = count_q;
    assign enq_fire      = bus.enq_valid && bus.enq_ready;

    // Per-port request vectors from registered state only.
    always_comb begin
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                req[f][i] = q[i].valid && q[i].src1_rdy && q[i].src2_rdy &&
                            q[i].elem.accept_mask[f];
            end
        end
    end

    // Pickers in series; each port excludes every earlier port's grant.
    for (genvar f = 0; f < NUM_FU; f++) begin : g_pick
        if (f == 0) begin : g_first
            assign excl[f] = '0;
        end else begin : g_rest
            assign excl[f] = excl[f-1] | grant[f-1];
        end
        iq_oldest_picker #(.DEPTH(DEPTH)) u_pick (
            .req   (req[f]),
            .excl  (excl[f]),
            .grant (grant[f]),
            .valid (pick_v[f]),
            .idx   (pick_idx[f])
        );
    end

    // Issue outputs and the set of entries leaving via a completed handshake.
    always_comb begin
        remove = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            bus.iss_valid[f] = pick_v[f];
            bus.iss_elem[f]  = q[pick_idx[f]].elem;
            remove = remove | (grant[f] & {DEPTH{bus.iss_ready[f]}});
        end
    end

    // Wakeup: capture broadcast values into waiting operands of stored entries.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            wake1[i] = wb_snoop(q[i].elem.num1_addr, bus.wb_valid, bus.wb_addr, bus.wb_data);
            wake2[i] = wb_snoop(q[i].elem.num2_addr, bus.wb_valid, bus.wb_addr, bus.wb_data);
            if (q[i].valid && !q[i].src1_rdy && wake1[i][32]) begin
                woken[i].src1_rdy  = 1'b1;
                woken[i].elem.num1 = wake1[i][31:0];
            end
            if (q[i].valid && !q[i].src2_rdy && wake2[i][32]) begin
                woken[i].src2_rdy  = 1'b1;
                woken[i].elem.num2 = wake2[i][31:0];
            end
        end
    end

    // Incoming entry with operand readiness resolved from decoder, regfile and bypass.
    always_comb begin
        enq_entry       = '0;
        enq_entry.valid = 1'b1;
        enq_entry.elem  = bus.enq_elem;
        enq_hit1 = wb_snoop(bus.enq_elem.num1_addr, bus.wb_valid, bus.wb_addr, bus.wb_data);
        enq_hit2 = wb_snoop(bus.enq_elem.num2_addr, bus.wb_valid, bus.wb_addr, bus.wb_data);
        if (!bus.enq_elem.num1_need) begin
            enq_entry.src1_rdy = 1'b1;
        end else if (bus.enq_elem.num1_addr == '0) begin
            enq_entry.src1_rdy  = 1'b1;
            enq_entry.elem.num1 = '0;
        end else if (bus.enq_src1_rdy) begin
            enq_entry.src1_rdy  = 1'b1;
            enq_entry.elem.num1 = bus.enq_src1_data;
        end else if (enq_hit1[32]) begin
            enq_entry.src1_rdy  = 1'b1;
            enq_entry.elem.num1 = enq_hit1[31:0];
        end
        if (!bus.enq_elem.num2_need) begin
            enq_entry.src2_rdy = 1'b1;
        end else if (bus.enq_elem.num2_addr == '0) begin
            enq_entry.src2_rdy  = 1'b1;
            enq_entry.elem.num2 = '0;
        end else if (bus.enq_src2_rdy) begin
            enq_entry.src2_rdy  = 1'b1;
            enq_entry.elem.num2 = bus.enq_src2_data;
        end else if (enq_hit2[32]) begin
            enq_entry.src2_rdy  = 1'b1;
            enq_entry.elem.num2 = enq_hit2[31:0];
        end
    end

    // Compaction: each survivor moves to the slot given by the count of older survivors.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) q_next[i] = '0;
        ptr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q[i].valid && !remove[i]) begin
                q_next[ptr[IW-1:0]] = woken[i];
                ptr = ptr + CW'(1);
            end
        end
        if (enq_fire) q_next[ptr[IW-1:0]] = enq_entry;
        count_next = ptr + CW'(enq_fire);
    end

    // State register; flush empties the queue and drops any same-cycle enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= q_next[i];
            count_q <= count_next;
        end
    end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Out-of-order issue queue between decoder and the three execution pipes.
- Holds decoded ISSUE_QUEUE_ELEMENT entries and captures operand values from writeback broadcasts.
- Each cycle, selects the oldest ready entry for each FU port, filtered by accept_mask.
- Flushed on branch mispredict.

Parameters:
- DEPTH, 8, number of queue entries (power of 2, 4..16).
- NUM_FU, 3, issue ports; bit f of accept_mask enables port f.
- WB_PORTS, 2, writeback broadcast ports snooped for wakeup.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (mispredict)
- enq_valid  in  1  decoder element valid
- enq_ready  out  1  queue can accept (count < DEPTH)
- enq_elem  in  ISSUE_QUEUE_ELEMENT  decoded element
- enq_src1_rdy  in  1  regfile reports num1_addr value committed
- enq_src1_data  in  32  regfile value for num1_addr
- enq_src2_rdy  in  1  regfile reports num2_addr value committed
- enq_src2_data  in  32  regfile value for num2_addr
- wb_valid  in  WB_PORTS  broadcast valid
- wb_addr  in  WB_PORTS x 5  destination register
- wb_data  in  WB_PORTS x 32  result
- iss_valid  out  NUM_FU  port f holds an issuable element
- iss_ready  in  NUM_FU  FU f accepts
- iss_elem  out  NUM_FU x ISSUE_QUEUE_ELEMENT  element with num1/num2 filled
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0): all entries invalid; count=0; enq_ready=1; iss_valid=0. rst_n low mid-operation drops everything immediately.
- Storage is a compacting age-ordered array: index 0 is oldest, valid entries are contiguous.
- Enqueue occurs when enq_valid && enq_ready; the new entry is appended after survivors.
- enq_ready = (count < DEPTH) from registered count only. It does not account for same-cycle issue.
- Operand readiness at enqueue: operand k is ready if any of:
  - num{k}_need=0 (num{k} kept as the decoder's value, e.g. immediate), or
  - addr==0 (value forced to 0), or
  - enq_src{k}_rdy=1 (take enq_src{k}_data), or
  - a same-cycle wb_valid[w] has wb_addr[w]==addr (take wb_data[w]; highest w wins).
- Wakeup: for each valid entry with operand not ready and wb_valid[w] && wb_addr[w]==addr, set ready and capture wb_data into num{k}. wb_addr==0 is ignored.
- Timing: broadcast in cycle N makes the entry eligible in N+1. An enqueued entry is eligible no earlier than the cycle after enqueue.
- Select is combinational from registered state:
  - Port 0 takes the oldest valid entry with both operands ready and accept_mask[0].
  - Port 1 takes the oldest such entry with accept_mask[1], excluding port 0's pick.
  - Port 2 likewise excludes picks of ports 0 and 1.
  - iss_elem[f] is the picked entry (captured data in num1/num2); all other fields pass through unchanged.
- Removal: an entry is removed when iss_valid[f] && iss_ready[f]. A picked-but-stalled entry stays and is re-selected next cycle.
- Up to NUM_FU removals plus one enqueue per cycle. Compaction is by prefix-count of survivors; order is preserved.
- count_next = count - removals + enq_fire.
- Dependencies: the upstream dispatch scoreboard guarantees at most one in-flight producer per architectural register. No tag renaming is done here.
- flush=1: all entries invalid next cycle, count=0. Same-cycle enqueue is discarded. iss_valid still reflects current state that cycle, but FU handshakes during a flush cycle are don't-care to the queue.
- Full with a simultaneous issue: enq_ready stays 0 that cycle (no bypass).

Decomposition:
- Shared package (defines.svh):
  - ISSUE_QUEUE_ELEMENT (existing).
  - New IQ_ENTRY = ISSUE_QUEUE_ELEMENT + valid, src1_rdy, src2_rdy.
  - FU index constants FU_ALU=0, FU_MEM=1, FU_BR=2.
- One natural sub-module: iq_oldest_picker (priority encoder over a request vector with an exclusion mask), instantiated NUM_FU times in series.

Test Plan:
- Reset then idle: rst_n low -> count=0, enq_ready=1, iss_valid=000.
- ADDIU with num1_addr=5, enq_src1_rdy=1, data=0x10, mask 111, enqueued cycle 0:
  - iss_valid[0]=1 at cycle 1 with num1=0x10.
  - iss_ready[0]=1 -> count returns 0 at cycle 2.
- LW (mask 011) enqueued with src1 not ready on r7; wb_valid[1]=1, wb_addr=7, data=0x2000 at cycle 3:
  - No issue before cycle 4.
  - Cycle 4 issues on port 0 with num1=0x2000.
- Eight ALU entries all ready, iss_ready=000:
  - count=8, enq_ready=0.
  - Raise iss_ready=111 -> three oldest leave; count=5 next cycle.
  - Order of remaining entries preserved.
- Two ready entries A (older) and B, mask 111, iss_ready[0]=0, iss_ready[1]=1 -> port0=A stalls, port1=B issues; A issues next cycle.
- flush with 5 entries plus a simultaneous enqueue -> count=0, iss_valid=000 next cycle; an entry with num1_addr=0 enqueued later issues with num1=0.
